// File: rtl/debug_frame_streamer_if.sv
// TX byte handshake between debug_frame_streamer (master) and usb_serial uart_tx_* (slave).
interface debug_frame_streamer_if;
   logic       tx_ready;
   logic       tx_strobe;
   logic [7:0] tx_data;

   modport master (input tx_ready, output tx_strobe, output tx_data);
   modport slave  (output tx_ready, input tx_strobe, input tx_data);
endinterface

// File: rtl/debug_frame_streamer.sv
// Snapshots an N-byte debug bus and streams SYNC + bytes (+ optional XOR checksum) to usb_serial.
// Optional checksum byte: define DEBUG_STREAM_CHECKSUM_EN.
module debug_frame_streamer #(
   parameter int         NUM_BYTES  = 8,
   parameter logic [7:0] SYNC_BYTE  = 8'hFF,
   parameter int         GAP_W      = 14,
   parameter int         STROBE_LEN = 4,
   parameter bit         FREE_RUN   = 1'b1
) (
   input  logic                   clk_48mhz,
   input  logic                   resetn,
   input  logic                   capture,
   input  logic [8*NUM_BYTES-1:0] data_in,
   debug_frame_streamer_if.master tx,
   output logic                   busy,
   output logic                   frame_done
);

   localparam int IDX_W = $clog2(NUM_BYTES + 3);
   localparam int STB_W = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
`ifdef DEBUG_STREAM_CHECKSUM_EN
   localparam int LAST_IDX = NUM_BYTES + 1;
`else
   localparam int LAST_IDX = NUM_BYTES;
`endif
   localparam logic [IDX_W-1:0] LAST = IDX_W'(LAST_IDX);

   typedef enum logic [1:0] {IDLE, GAP, STROBE, DONE} state_t;

   state_t                 state_q, state_d;
   logic                   cap_q, cap_d;
   logic                   pending_q, pending_d;
   logic                   restart_q, restart_d;
   logic [8*NUM_BYTES-1:0] snap_q, snap_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
   logic                   gap_wait_q, gap_wait_d;
   logic [STB_W-1:0]       stb_cnt_q, stb_cnt_d;
   logic [7:0]             tx_data_q, tx_data_d;

   logic       cap_edge;
   logic       gap_expired;
   logic       stb_last;
   logic [7:0] next_byte;

   assign cap_edge    = capture & ~cap_q;
   // Once the counter has wrapped, gap_wait_q holds the expiry until tx_ready arrives.
   assign gap_expired = (gap_cnt_q == '1) | gap_wait_q;
   assign stb_last    = (stb_cnt_q == STB_W'(STROBE_LEN - 1));

`ifdef DEBUG_STREAM_CHECKSUM_EN
   logic [7:0] checksum;

   always_comb begin
      checksum = 8'h00;
      for (int k = 0; k < NUM_BYTES; k++) begin
         checksum = checksum ^ snap_q[8*k +: 8];
      end
   end
`endif

   // idx 0 is SYNC, 1..NUM_BYTES the snapshot, NUM_BYTES+1 the checksum when enabled.
   always_comb begin
      next_byte = SYNC_BYTE;
      for (int k = 0; k < NUM_BYTES; k++) begin
         if (idx_q == IDX_W'(k + 1)) next_byte = snap_q[8*k +: 8];
      end
`ifdef DEBUG_STREAM_CHECKSUM_EN
      if (idx_q == IDX_W'(NUM_BYTES + 1)) next_byte = checksum;
`endif
   end

   // NOTE: synchronous reset -- resetn is only looked at on a clk_48mhz edge, like the rest of top.
   always_ff @(posedge clk_48mhz) begin
      if (!resetn) begin
         // NOTE: <= in clocked blocks so every flop samples pre-edge values regardless of order.
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (restart_q || cap_edge || FREE_RUN) state_d = GAP;
         GAP:     if (gap_expired && tx.tx_ready) state_d = STROBE;
         STROBE:  if (stb_last) state_d = (idx_q == LAST) ? DONE : GAP;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx.tx_strobe = (state_q == STROBE);
      tx.tx_data   = tx_data_q;
      busy         = (state_q != IDLE);
      frame_done   = (state_q == DONE);
   end

   always_comb begin
      // NOTE: every _d starts from its held value so no branch leaves it unassigned (no latches).
      cap_d      = capture;
      pending_d  = pending_q;
      restart_d  = restart_q;
      snap_d     = snap_q;
      idx_d      = idx_q;
      gap_cnt_d  = gap_cnt_q;
      gap_wait_d = gap_wait_q;
      stb_cnt_d  = stb_cnt_q;
      tx_data_d  = tx_data_q;

      unique case (state_q)
         IDLE: begin
            gap_cnt_d  = '0;
            gap_wait_d = 1'b0;
            stb_cnt_d  = '0;
            if (restart_q) begin
               // Snapshot was already taken in DONE; a fresh edge here queues another frame.
               restart_d = 1'b0;
               idx_d     = '0;
               if (cap_edge) pending_d = 1'b1;
            end else if (cap_edge || FREE_RUN) begin
               snap_d = data_in;
               idx_d  = '0;
            end
         end
         GAP: begin
            if (cap_edge) pending_d = 1'b1;
            if (gap_expired) begin
               gap_cnt_d = '0;
               if (tx.tx_ready) begin
                  tx_data_d  = next_byte;
                  gap_wait_d = 1'b0;
                  stb_cnt_d  = '0;
               end else begin
                  gap_wait_d = 1'b1;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         STROBE: begin
            if (cap_edge) pending_d = 1'b1;
            if (stb_last) begin
               stb_cnt_d = '0;
               idx_d     = idx_q + IDX_W'(1);
            end else begin
               stb_cnt_d = stb_cnt_q + STB_W'(1);
            end
         end
         DONE: begin
            if (pending_q || cap_edge) begin
               pending_d = 1'b0;
               restart_d = 1'b1;
               snap_d    = data_in;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_48mhz) begin
      if (!resetn) begin
         cap_q      <= 1'b0;
         pending_q  <= 1'b0;
         restart_q  <= 1'b0;
         // NOTE: the snapshot bank is cleared too, so nothing stale can be replayed after reset.
         snap_q     <= '0;
         idx_q      <= '0;
         gap_cnt_q  <= '0;
         gap_wait_q <= 1'b0;
         stb_cnt_q  <= '0;
         tx_data_q  <= 8'h00;
      end else begin
         cap_q      <= cap_d;
         pending_q  <= pending_d;
         restart_q  <= restart_d;
         snap_q     <= snap_d;
         idx_q      <= idx_d;
         gap_cnt_q  <= gap_cnt_d;
         gap_wait_q <= gap_wait_d;
         stb_cnt_q  <= stb_cnt_d;
         tx_data_q  <= tx_data_d;
      end
   end

endmodule

// File: tb/tb_debug_frame_streamer.sv
// Scoreboard bench: stimulus pushes expected frame bytes, negedge monitors pop and compare each strobe.
module tb_debug_frame_streamer;

   localparam int NB = 4;
   localparam int GW = 3;
   localparam int SL = 4;
`ifdef DEBUG_STREAM_CHECKSUM_EN
   localparam int FLEN = NB + 2;
`else
   localparam int FLEN = NB + 1;
`endif
   localparam int GAP_CYCLES = 1 << GW;

   logic clk_48mhz = 1'b0;
   always #5 clk_48mhz = ~clk_48mhz;

   logic            resetn, rst1_n;
   logic            capture, capture1;
   logic [8*NB-1:0] data_in, data_in1;
   logic            busy0, fd0, busy1, fd1;

   debug_frame_streamer_if tx0 ();
   debug_frame_streamer_if tx1 ();

   debug_frame_streamer #(
      .NUM_BYTES(NB), .SYNC_BYTE(8'hFF), .GAP_W(GW), .STROBE_LEN(SL), .FREE_RUN(1'b0)
   ) dut0 (
      .clk_48mhz(clk_48mhz), .resetn(resetn), .capture(capture), .data_in(data_in),
      .tx(tx0), .busy(busy0), .frame_done(fd0)
   );

   debug_frame_streamer #(
      .NUM_BYTES(NB), .SYNC_BYTE(8'hFF), .GAP_W(GW), .STROBE_LEN(SL), .FREE_RUN(1'b1)
   ) dut1 (
      .clk_48mhz(clk_48mhz), .resetn(rst1_n), .capture(capture1), .data_in(data_in1),
      .tx(tx1), .busy(busy1), .frame_done(fd1)
   );

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q [$];
   int         n_strobe0 = 0;
   int         n_strobe1 = 0;
   bit         chk_gap = 1'b0;
   logic [7:0] frame1 [FLEN];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Reference frame: SYNC, bytes 0..N-1, then XOR of data bytes if enabled.
   task automatic push_frame(input logic [8*NB-1:0] d);
      logic [7:0] x;
      x = 8'h00;
      exp_q.push_back(8'hFF);
      for (int k = 0; k < NB; k++) begin
         exp_q.push_back(d[8*k +: 8]);
         x = x ^ d[8*k +: 8];
      end
`ifdef DEBUG_STREAM_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   // Monitor for the capture-triggered instance.
   logic       prev_stb0 = 1'b0;
   logic       prev_fd0  = 1'b0;
   logic [7:0] held0;
   int         len0 = 0;
   int         low0 = -1;

   always @(negedge clk_48mhz) begin
      if (!resetn) begin
         prev_stb0 = 1'b0;
         prev_fd0  = 1'b0;
         len0      = 0;
         low0      = -1;
      end else begin
         if (tx0.tx_strobe && !prev_stb0) begin
            n_strobe0++;
            if (chk_gap && low0 >= 0) check("gap_len", low0, GAP_CYCLES);
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL spurious_strobe: tx_data=%0h with no byte expected", tx0.tx_data);
            end else begin
               check("tx_data", {24'h0, tx0.tx_data}, {24'h0, exp_q.pop_front()});
            end
            held0 = tx0.tx_data;
            len0  = 1;
         end else if (tx0.tx_strobe) begin
            check("tx_data_stable", {24'h0, tx0.tx_data}, {24'h0, held0});
            len0++;
         end else if (prev_stb0) begin
            check("strobe_len", len0, SL);
         end
         if (!tx0.tx_strobe) begin
            if (prev_stb0) low0 = 1;
            else if (low0 >= 0) low0++;
         end
         if (!busy0) low0 = -1;
         if (fd0) begin
            check("frame_done_pulse", {31'h0, prev_fd0}, 0);
            check("done_after_strobe", {31'h0, prev_stb0}, 1);
         end
         prev_stb0 = tx0.tx_strobe;
         prev_fd0  = fd0;
      end
   end

   // Monitor for the free-running instance: every strobe follows the repeating frame from SYNC.
   logic prev_stb1 = 1'b0;
   int   pos1 = 0;

   always @(negedge clk_48mhz) begin
      if (!rst1_n) begin
         pos1      = 0;
         prev_stb1 = 1'b0;
      end else begin
         if (tx1.tx_strobe && !prev_stb1) begin
            check("fr_tx_data", {24'h0, tx1.tx_data}, {24'h0, frame1[pos1]});
            pos1 = (pos1 + 1) % FLEN;
            n_strobe1++;
         end
         prev_stb1 = tx1.tx_strobe;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_48mhz);
         #1;
      end
   endtask

   task automatic edge0();
      capture = 1'b1;
      tick(1);
      capture = 1'b0;
      tick(1);
   endtask

   task automatic wait_idle0(input string name);
      int c;
      c = 0;
      while (busy0 && c < 2000) begin
         tick(1);
         c++;
      end
      check({name, "_idle"}, {31'h0, busy0}, 0);
   endtask

   task automatic wait_done0(input string name);
      int c;
      c = 0;
      while (!fd0 && c < 2000) begin
         tick(1);
         c++;
      end
      check({name, "_done_seen"}, {31'h0, fd0}, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8*NB-1:0] d, y;
      logic [7:0]      x;
      int              base, c;

      resetn = 1'b0; rst1_n = 1'b0;
      capture = 1'b0; capture1 = 1'b0;
      data_in = '0;
      tx0.tx_ready = 1'b1; tx1.tx_ready = 1'b1;
      data_in1 = $urandom;
      x = 8'h00;
      frame1[0] = 8'hFF;
      for (int k = 0; k < NB; k++) begin
         frame1[k+1] = data_in1[8*k +: 8];
         x = x ^ data_in1[8*k +: 8];
      end
`ifdef DEBUG_STREAM_CHECKSUM_EN
      frame1[NB+1] = x;
`endif
      tick(3);
      check("rst_strobe", {31'h0, tx0.tx_strobe}, 0);
      check("rst_data", {24'h0, tx0.tx_data}, 0);
      check("rst_busy", {31'h0, busy0}, 0);
      check("rst_done", {31'h0, fd0}, 0);
      check("rst_fr_strobe", {31'h0, tx1.tx_strobe}, 0);
      check("rst_fr_busy", {31'h0, busy1}, 0);
      resetn = 1'b1;
      tick(3);
      check("idle_no_capture", {31'h0, busy0}, 0);

      // Single frame, tx_ready always high, gap length checked.
      chk_gap = 1'b1;
      base = n_strobe0;
      data_in = 32'h44332211;
      push_frame(data_in);
      edge0();
      wait_idle0("t1");
      tick(60);
      check("t1_strobe_count", n_strobe0 - base, FLEN);
      check("t1_queue_empty", exp_q.size(), 0);
      chk_gap = 1'b0;

      // Data change mid-frame must not tear; next capture picks up the new value.
      base = n_strobe0;
      push_frame(data_in);
      edge0();
      c = 0;
      while (n_strobe0 < base + 2 && c < 500) begin tick(1); c++; end
      check("t3_two_strobes", {31'h0, n_strobe0 >= base + 2}, 1);
      data_in = 32'hAABBCCDD;
      wait_idle0("t3a");
      push_frame(data_in);
      edge0();
      wait_idle0("t3b");
      check("t3_queue_empty", exp_q.size(), 0);

      // Three edges while busy coalesce into exactly one extra frame, snapshot taken at DONE.
      base = n_strobe0;
      d = $urandom;
      data_in = d;
      push_frame(d);
      edge0();
      repeat (3) edge0();
      y = $urandom;
      data_in = y;
      push_frame(y);
      wait_done0("t4");
      tick(1);
      c = 0;
      while (!busy0 && c < 10) begin tick(1); c++; end
      check("t4_idle_cycles", c, 1);
      wait_idle0("t4");
      tick(60);
      check("t4_strobe_count", n_strobe0 - base, 2 * FLEN);
      check("t4_queue_empty", exp_q.size(), 0);

      // Capture edge landing in the DONE cycle still yields a following frame.
      d = $urandom;
      data_in = d;
      push_frame(d);
      edge0();
      wait_done0("t4b");
      y = $urandom;
      data_in = y;
      capture = 1'b1;
      push_frame(y);
      tick(1);
      capture = 1'b0;
      tick(3);
      wait_idle0("t4b");
      tick(40);
      check("t4b_queue_empty", exp_q.size(), 0);

      // tx_ready held low across gap expiry.
      d = $urandom;
      data_in = d;
      push_frame(d);
      edge0();
      tx0.tx_ready = 1'b0;
      base = n_strobe0;
      tick(50);
      check("t5_no_strobe", n_strobe0 - base, 0);
      check("t5_strobe_low", {31'h0, tx0.tx_strobe}, 0);
      tx0.tx_ready = 1'b1;
      tick(1);
      check("t5_strobe_start", {31'h0, tx0.tx_strobe}, 1);
      wait_idle0("t5");

      // Randomized frames with tx_ready jitter and data churn mid-frame.
      repeat (8) begin
         d = $urandom;
         data_in = d;
         push_frame(d);
         edge0();
         c = 0;
         while (busy0 && c < 600) begin
            if ($urandom_range(0, 9) == 0) data_in = $urandom;
            tx0.tx_ready = ($urandom_range(0, 3) != 0);
            tick(1);
            c++;
         end
         tx0.tx_ready = 1'b1;
         wait_idle0("rand");
      end
      tick(40);
      check("rand_queue_empty", exp_q.size(), 0);

      // Free-running instance: reset during byte 2, restart begins with SYNC.
      rst1_n = 1'b1;
      c = 0;
      while (!(n_strobe1 == 3 && tx1.tx_strobe) && c < 500) begin tick(1); c++; end
      check("t6_in_byte2", {31'h0, tx1.tx_strobe}, 1);
      rst1_n = 1'b0;
      tick(1);
      check("t6_rst_strobe", {31'h0, tx1.tx_strobe}, 0);
      check("t6_rst_data", {24'h0, tx1.tx_data}, 0);
      check("t6_rst_busy", {31'h0, busy1}, 0);
      check("t6_rst_done", {31'h0, fd1}, 0);
      tick(3);
      rst1_n = 1'b1;
      c = 0;
      while (!tx1.tx_strobe && c < 200) begin tick(1); c++; end
      check("t6_first_sync", {24'h0, tx1.tx_data}, 32'hFF);
      base = n_strobe1;
      tick(200);
      check("t6_frames_continue", {31'h0, (n_strobe1 - base) >= FLEN}, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
